// File: rtl/udp_port_demux_filter_if.sv
// UDP header/payload sink bundle plus the per-channel AXI-Stream outputs of the demux.
// master = upstream/downstream environment side, slave = demux side.
interface udp_port_demux_filter_if #(
  parameter int CHANNELS   = 4,
  parameter int DATA_WIDTH = 8
);
  logic                           s_udp_hdr_valid;
  logic                           s_udp_hdr_ready;
  logic [31:0]                    s_udp_ip_dest_ip;
  logic [15:0]                    s_udp_dest_port;
  logic [DATA_WIDTH-1:0]          s_udp_payload_axis_tdata;
  logic                           s_udp_payload_axis_tvalid;
  logic                           s_udp_payload_axis_tready;
  logic                           s_udp_payload_axis_tlast;
  logic                           s_udp_payload_axis_tuser;
  logic [CHANNELS*DATA_WIDTH-1:0] m_axis_tdata;
  logic [CHANNELS-1:0]            m_axis_tvalid;
  logic [CHANNELS-1:0]            m_axis_tready;
  logic [CHANNELS-1:0]            m_axis_tlast;
  logic [CHANNELS-1:0]            m_axis_tuser;

  modport slave (
    input  s_udp_hdr_valid, s_udp_ip_dest_ip, s_udp_dest_port,
    input  s_udp_payload_axis_tdata, s_udp_payload_axis_tvalid,
    input  s_udp_payload_axis_tlast, s_udp_payload_axis_tuser,
    output s_udp_hdr_ready, s_udp_payload_axis_tready,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
    input  m_axis_tready
  );

  modport master (
    output s_udp_hdr_valid, s_udp_ip_dest_ip, s_udp_dest_port,
    output s_udp_payload_axis_tdata, s_udp_payload_axis_tvalid,
    output s_udp_payload_axis_tlast, s_udp_payload_axis_tuser,
    input  s_udp_hdr_ready, s_udp_payload_axis_tready,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
    output m_axis_tready
  );
endinterface

// File: rtl/udp_port_demux_filter.sv
// Routes UDP payload to the first enabled (dest IP, dest port) rule's channel, drains and counts misses.
// 1 clk payload latency through one shared output register; stalls upstream only while that register is held.
module udp_port_demux_filter #(
  parameter int CHANNELS   = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tx_eth_hdr_ready,
  udp_port_demux_filter_if.slave        bus,
  input  logic [CHANNELS-1:0]           cfg_enable,
  input  logic [CHANNELS-1:0]           cfg_ip_any,
  input  logic [CHANNELS*32-1:0]        cfg_dest_ip,
  input  logic [CHANNELS*16-1:0]        cfg_dest_port,
  output logic [CHANNELS*CNT_WIDTH-1:0] status_frame_count,
  output logic [CHANNELS*CNT_WIDTH-1:0] status_bad_count,
  output logic [CNT_WIDTH-1:0]          status_drop_count,
  output logic                          status_busy
);
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FWD   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]            state;
  logic [CHANNELS-1:0]   hit;
  logic                  any_hit;
  logic [SEL_W-1:0]      hit_sel;
  logic [SEL_W-1:0]      sel;
  logic [SEL_W-1:0]      out_ch;
  logic                  out_valid;
  logic                  out_last;
  logic                  out_user;
  logic [DATA_WIDTH-1:0] out_data;
  logic [CNT_WIDTH-1:0]  frame_cnt [CHANNELS];
  logic [CNT_WIDTH-1:0]  bad_cnt   [CHANNELS];
  logic [CNT_WIDTH-1:0]  drop_cnt;
  logic                  hdr_fire;
  logic                  in_fire;
  logic                  out_fire;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  always_comb begin
    hit     = '0;
    hit_sel = '0;
    for (int i = 0; i < CHANNELS; i++)
      hit[i] = cfg_enable[i] && (cfg_dest_port[i*16 +: 16] == bus.s_udp_dest_port) &&
               (cfg_ip_any[i] || (cfg_dest_ip[i*32 +: 32] == bus.s_udp_ip_dest_ip));
    // Descending scan so the lowest matching index is the one left standing.
    for (int i = CHANNELS - 1; i >= 0; i--)
      if (hit[i]) hit_sel = SEL_W'(i);
  end

  assign any_hit = |hit;

  always_comb begin
    bus.s_udp_hdr_ready           = 1'b0;
    bus.s_udp_payload_axis_tready = 1'b0;
    case (state)
      IDLE:    bus.s_udp_hdr_ready = any_hit ? tx_eth_hdr_ready : 1'b1;
      // A held beat may belong to the previous frame's channel, so gate on out_ch, not sel.
      FWD:     bus.s_udp_payload_axis_tready = !out_valid || bus.m_axis_tready[out_ch];
      DRAIN:   bus.s_udp_payload_axis_tready = 1'b1;
      default: ;
    endcase
  end

  assign hdr_fire = bus.s_udp_hdr_valid && bus.s_udp_hdr_ready;
  assign in_fire  = bus.s_udp_payload_axis_tvalid && bus.s_udp_payload_axis_tready;
  assign out_fire = out_valid && bus.m_axis_tready[out_ch];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= '0;
    end else begin
      case (state)
        IDLE: if (hdr_fire) begin
          sel   <= hit_sel;
          state <= any_hit ? FWD : DRAIN;
        end
        FWD, DRAIN: if (in_fire && bus.s_udp_payload_axis_tlast) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_user  <= 1'b0;
      out_ch    <= '0;
    end else if (state == FWD && in_fire) begin
      out_valid <= 1'b1;
      out_data  <= bus.s_udp_payload_axis_tdata;
      out_last  <= bus.s_udp_payload_axis_tlast;
      out_user  <= bus.s_udp_payload_axis_tuser;
      out_ch    <= sel;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        frame_cnt[c] <= '0;
        bad_cnt[c]   <= '0;
      end
      drop_cnt <= '0;
    end else begin
      if (out_fire && out_last) begin
        if (out_user) bad_cnt[out_ch]   <= sat_inc(bad_cnt[out_ch]);
        else          frame_cnt[out_ch] <= sat_inc(frame_cnt[out_ch]);
      end
      if (state == DRAIN && in_fire && bus.s_udp_payload_axis_tlast)
        drop_cnt <= sat_inc(drop_cnt);
    end
  end

  always_comb begin
    bus.m_axis_tdata   = '0;
    bus.m_axis_tvalid  = '0;
    bus.m_axis_tlast   = '0;
    bus.m_axis_tuser   = '0;
    status_frame_count = '0;
    status_bad_count   = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (out_valid && out_ch == SEL_W'(c)) begin
        bus.m_axis_tvalid[c]                          = 1'b1;
        bus.m_axis_tdata[c*DATA_WIDTH +: DATA_WIDTH] = out_data;
        bus.m_axis_tlast[c]                           = out_last;
        bus.m_axis_tuser[c]                           = out_user;
      end
      status_frame_count[c*CNT_WIDTH +: CNT_WIDTH] = frame_cnt[c];
      status_bad_count[c*CNT_WIDTH +: CNT_WIDTH]   = bad_cnt[c];
    end
  end

  assign status_drop_count = drop_cnt;
  assign status_busy       = (state != IDLE);
endmodule
